// File: rtl/dmem_lsu.sv
// Load/store unit between the core MEM stage and the external data bus.
// Latency: accept at E0, zero-wait ack sampled at E1, resp_valid pulses for the cycle after E1.
// Backpressure: req_ready is high only in IDLE; the MEM stage holds its request while it is low.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_ready       request handshake (accept = valid & ready at a rising edge)
//   req_write, req_size,      request fields: store flag, size (00 word, 01 half, else byte),
//   req_unsigned, req_addr,   zero/sign-extend select for loads, byte address,
//   req_wdata                 right-aligned store data
//   resp_valid, resp_rdata,   one-cycle completion pulse with extended load data,
//   resp_misalign,            alignment reject flag,
//   resp_bus_err              ack timeout flag
//   DAD, MREQ, WRITE, SIZE    bus address, request, direction and size
//   ACKD_n                    active-low bus ack, only looked at while in ACCESS
//   DDT                       bidirectional bus data, driven only during a store access
module dmem_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit CHECK_ALIGN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_bus_err,
  output logic [31:0] DAD,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  input  logic        ACKD_n,
  inout  wire  [31:0] DDT
);

  // Counter wide enough to hold TIMEOUT_CYCLES; the abort fires when the
  // count would step from TIMEOUT_CYCLES-1 to TIMEOUT_CYCLES.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   dad_q, dad_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          mreq_q, mreq_d;
  logic          uns_q, uns_d;
  logic [31:0]   wlane_q, wlane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;
  logic          err_q, err_d;

  logic          misalign;
  logic [31:0]   load_ext;
  logic [31:0]   store_lane;

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = rvalid_q;
  assign resp_rdata    = rdata_q;
  assign resp_misalign = mis_q;
  assign resp_bus_err  = err_q;
  assign DAD           = dad_q;
  assign MREQ          = mreq_q;
  assign WRITE         = write_q;
  assign SIZE          = size_q;

  assign DDT = (mreq_q & write_q) ? wlane_q : 32'hz;

  assign misalign = CHECK_ALIGN &&
                    (((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b00) && (req_addr[1:0] != 2'b00)));

  // Store data is right-aligned; only the lanes of the access size are kept.
  always_comb begin
    store_lane = {24'b0, req_wdata[7:0]};
    case (req_size)
      2'b00:   store_lane = req_wdata;
      2'b01:   store_lane = {16'b0, req_wdata[15:0]};
      default: store_lane = {24'b0, req_wdata[7:0]};
    endcase
  end

  // Load data comes in on the low lanes of DDT; extend using the latched size.
  always_comb begin
    load_ext = {{24{~uns_q & DDT[7]}}, DDT[7:0]};
    case (size_q)
      2'b00:   load_ext = DDT;
      2'b01:   load_ext = {{16{~uns_q & DDT[15]}}, DDT[15:0]};
      default: load_ext = {{24{~uns_q & DDT[7]}}, DDT[7:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dad_q    <= 32'h0;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
      mreq_q   <= 1'b0;
      uns_q    <= 1'b0;
      wlane_q  <= 32'h0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dad_q    <= dad_d;
      size_q   <= size_d;
      write_q  <= write_d;
      mreq_q   <= mreq_d;
      uns_q    <= uns_d;
      wlane_q  <= wlane_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dad_d    = dad_q;
    size_d   = size_q;
    write_d  = write_q;
    mreq_d   = mreq_q;
    uns_d    = uns_q;
    wlane_d  = wlane_q;
    cnt_d    = cnt_q;
    // Response fields are pulses: cleared unless set this cycle.
    rvalid_d = 1'b0;
    rdata_d  = 32'h0;
    mis_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            // Rejected without touching the bus; the FSM stays in IDLE.
            rvalid_d = 1'b1;
            mis_d    = 1'b1;
          end else begin
            state_d = ACCESS;
            dad_d   = req_addr;
            size_d  = req_size;
            write_d = req_write;
            mreq_d  = 1'b1;
            uns_d   = req_unsigned;
            wlane_d = store_lane;
            cnt_d   = '0;
          end
        end
      end
      ACCESS: begin
        if (!ACKD_n) begin
          state_d  = IDLE;
          mreq_d   = 1'b0;
          write_d  = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = write_q ? 32'h0 : load_ext;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
            state_d  = IDLE;
            mreq_d   = 1'b0;
            write_d  = 1'b0;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: table of single accesses plus reset,
// stale-ack and mid-access reset sequences. Timeout is set to 4 cycles.
module tb_dmem_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_bus_err;
  logic [31:0] DAD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;
  wire  [31:0] DDT;

  // Memory side of the bus; a pulldown makes a released bus read as 0.
  logic        mem_en;
  logic [31:0] mem_dat;
  assign DDT = mem_en ? mem_dat : 32'hz;
  pulldown (DDT);

  int n_cmp = 0;
  int n_err = 0;

  dmem_lsu #(.TIMEOUT_CYCLES(4), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .resp_bus_err(resp_bus_err),
    .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .ACKD_n(ACKD_n), .DDT(DDT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          wait_n;   // MREQ cycles with ACKD_n=1 before the ack
    logic        e_mis;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_ddt;    // bus data expected while MREQ is up (0 = released)
    int          e_mreq;   // expected number of cycles MREQ is high
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mem, input int wt,
                              input logic emis, input logic eerr,
                              input logic [31:0] erd, input logic [31:0] eddt,
                              input int emreq);
    vec_t v;
    v.wr = wr; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.mem = mem; v.wait_n = wt; v.e_mis = emis; v.e_err = eerr;
    v.e_rdata = erd; v.e_ddt = eddt; v.e_mreq = emreq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          mcnt;
    bit          seen;
    logic [31:0] r_rdata;
    logic [31:0] r_ddt;
    logic        r_mis;
    logic        r_err;
    mcnt = 0; seen = 0; r_rdata = '0; r_ddt = '0; r_mis = 0; r_err = 0;
    @(negedge clk);
    chk($sformatf("v%0d req_ready_idle", idx), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; ACKD_n = 1'b1; mem_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      if (resp_valid) begin
        seen = 1; r_rdata = resp_rdata; r_mis = resp_misalign; r_err = resp_bus_err;
        r_ddt = DDT;
      end else if (MREQ) begin
        mcnt++;
        if (mcnt == 1) begin
          chk($sformatf("v%0d req_ready_busy", idx), {31'b0, req_ready}, 32'd0);
          chk($sformatf("v%0d DAD", idx), DAD, v.addr);
          chk($sformatf("v%0d SIZE", idx), {30'b0, SIZE}, {30'b0, v.size});
          chk($sformatf("v%0d WRITE", idx), {31'b0, WRITE}, {31'b0, v.wr});
          chk($sformatf("v%0d DDT_access", idx), DDT, v.e_ddt);
        end
        if (mcnt > v.wait_n) begin
          ACKD_n = 1'b0; mem_en = ~v.wr; mem_dat = v.mem;
        end else begin
          ACKD_n = 1'b1; mem_en = 1'b0;
        end
      end
    end
    ACKD_n = 1'b1; mem_en = 1'b0;
    chk($sformatf("v%0d resp_seen", idx), {31'b0, seen}, 32'd1);
    chk($sformatf("v%0d rdata", idx), r_rdata, v.e_rdata);
    chk($sformatf("v%0d misalign", idx), {31'b0, r_mis}, {31'b0, v.e_mis});
    chk($sformatf("v%0d bus_err", idx), {31'b0, r_err}, {31'b0, v.e_err});
    chk($sformatf("v%0d mreq_cycles", idx), mcnt, v.e_mreq);
    if (v.wr) chk($sformatf("v%0d DDT_release", idx), r_ddt, 32'h0);
    @(negedge clk);
    chk($sformatf("v%0d resp_pulse", idx), {31'b0, resp_valid}, 32'd0);
    chk($sformatf("v%0d mreq_low", idx), {31'b0, MREQ}, 32'd0);
  endtask

  initial begin
    int hits;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; ACKD_n = 1'b1;
    mem_en = 1'b0; mem_dat = '0;

    //            wr  size   uns  addr          wdata         mem           wt mis err rdata         ddt           mreq
    vq.push_back(mk(0, 2'b00, 0, 32'h0800_0004, 32'h0,        32'h8000_0001, 0, 0, 0, 32'h8000_0001, 32'h0,        1));
    vq.push_back(mk(0, 2'b10, 0, 32'h0800_0003, 32'h0,        32'h1234_56F0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,        1));
    vq.push_back(mk(0, 2'b10, 1, 32'h0800_0003, 32'h0,        32'h1234_56F0, 0, 0, 0, 32'h0000_00F0, 32'h0,        1));
    vq.push_back(mk(1, 2'b01, 0, 32'h0800_0002, 32'h1234_ABCD, 32'h0,        0, 0, 0, 32'h0,        32'h0000_ABCD, 1));
    vq.push_back(mk(0, 2'b00, 0, 32'h0800_0002, 32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 2'b01, 0, 32'h0800_0006, 32'h0,        32'hDEAD_8001, 2, 0, 0, 32'hFFFF_8001, 32'h0,        3));
    vq.push_back(mk(0, 2'b01, 1, 32'h0800_000A, 32'h0,        32'hFFFF_8001, 0, 0, 0, 32'h0000_8001, 32'h0,        1));
    vq.push_back(mk(0, 2'b01, 0, 32'h0800_0001, 32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,        0));
    vq.push_back(mk(1, 2'b10, 0, 32'h0800_0005, 32'hAABB_CCDD, 32'h0,        0, 0, 0, 32'h0,        32'h0000_00DD, 1));
    vq.push_back(mk(1, 2'b00, 0, 32'hF000_0000, 32'hCAFE_F00D, 32'h0,        1, 0, 0, 32'h0,        32'hCAFE_F00D, 2));
    vq.push_back(mk(0, 2'b00, 0, 32'h0800_0010, 32'h0,        32'h1357_9BDF, 3, 0, 0, 32'h1357_9BDF, 32'h0,        4));
    vq.push_back(mk(0, 2'b00, 0, 32'h0800_0014, 32'h0,        32'h5555_5555, 10, 0, 1, 32'h0,       32'h0,        4));
    vq.push_back(mk(0, 2'b11, 0, 32'h0800_0007, 32'h0,        32'h0000_0080, 0, 0, 0, 32'hFFFF_FF80, 32'h0,        1));
    vq.push_back(mk(1, 2'b00, 0, 32'hFF00_0000, 32'h0000_0001, 32'h0,        0, 0, 0, 32'h0,        32'h0000_0001, 1));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst MREQ", {31'b0, MREQ}, 32'd0);
    chk("rst WRITE", {31'b0, WRITE}, 32'd0);
    chk("rst DAD", DAD, 32'h0);
    chk("rst SIZE", {30'b0, SIZE}, 32'd0);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst flags", {30'b0, resp_misalign, resp_bus_err}, 32'd0);
    chk("rst DDT", DDT, 32'h0);

    // Ack low while idle must do nothing
    hits = 0;
    ACKD_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (MREQ || resp_valid) hits++;
    end
    ACKD_n = 1'b1;
    chk("idle_ack ignored", hits, 0);

    foreach (vq[i]) run_vec(i, vq[i]);

    // Reset in the middle of an access: bus drops, no response
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h0800_0020;
    req_wdata = 32'h0F0F_0F0F; ACKD_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst MREQ_up", {31'b0, MREQ}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst MREQ", {31'b0, MREQ}, 32'd0);
    chk("midrst WRITE", {31'b0, WRITE}, 32'd0);
    chk("midrst DAD", DAD, 32'h0);
    chk("midrst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst DDT", DDT, 32'h0);
    rst = 1'b0;
    hits = 0;
    ACKD_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid || MREQ) hits++;
    end
    ACKD_n = 1'b1;
    chk("midrst no_resp", hits, 0);

    // Recovery after the aborted access
    run_vec(100, vq[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
